chebyshev_computation_v2: RTL and testbench

CHEBYSHEV_COMPUTATION_V2 -- requirements
Module: chebyshev_computation_v2

---
 rtl/chebyshev_computation_v2_pkg.sv | 11 +
 rtl/cheb_mult_stage.sv | 26 ++
 rtl/chebyshev_computation_v2.sv | 54 +++++
 tb/tb_chebyshev_computation_v2.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/chebyshev_computation_v2_pkg.sv
// Shared sizing for the Chebyshev c*x*x pipeline: output width and stage count.
package chebyshev_computation_v2_pkg;

    localparam int PIPE_DEPTH = 3;

    // x*x needs 2*WL bits and the product with c adds CL more; it is always exact.
    function automatic int out_w(input int wl, input int cl, input int widening);
        return 2*wl + cl + widening;
    endfunction

endpackage

// File: rtl/cheb_mult_stage.sv
// Signed multiplier with an async-reset output register; the result is sign-extended to PW bits.
module cheb_mult_stage #(
    parameter int AW = 8,
    parameter int BW = 8,
    parameter int PW = AW + BW
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic signed [AW-1:0] a,
    input  logic signed [BW-1:0] b,
    output logic signed [PW-1:0] p
);

    // Operands are widened first, so the product is formed directly at output width.
    logic signed [PW-1:0] ae;
    logic signed [PW-1:0] be;

    assign ae = PW'(a);
    assign be = PW'(b);

    always_ff @(posedge clock or posedge resetn) begin
        if (resetn) p <= '0;
        else        p <= ae * be;
    end

endmodule

// File: rtl/chebyshev_computation_v2.sv
// Three-stage pipeline computing data_out = c * x * x at full precision, one pair per cycle.
module chebyshev_computation_v2
    import chebyshev_computation_v2_pkg::*;
#(
    parameter int WL       = 8,
    parameter int CL       = 8,
    parameter int WIDENING = 0
) (
    input  logic                                         clock,
    input  logic                                         resetn,
    input  logic signed [WL-1:0]                         data_in,
    input  logic signed [CL-1:0]                         coeff_in,
    output logic signed [out_w(WL, CL, WIDENING)-1:0]    data_out
);

    localparam int OUT = out_w(WL, CL, WIDENING);

    logic signed [WL-1:0]   x_r;
    logic signed [CL-1:0]   c_r;
    logic signed [CL-1:0]   c_d;
    logic signed [2*WL-1:0] sq;

    // Stage 1: capture the sample pair; the resetn name is kept but it is active high.
    always_ff @(posedge clock or posedge resetn) begin
        if (resetn) begin
            x_r <= '0;
            c_r <= '0;
            c_d <= '0;
        end else begin
            x_r <= data_in;
            c_r <= coeff_in;
            c_d <= c_r;
        end
    end

    // Stage 2: square of x, with c_d keeping the coefficient aligned.
    cheb_mult_stage #(.AW(WL), .BW(WL), .PW(2*WL)) u_sq (
        .clock  (clock),
        .resetn (resetn),
        .a      (x_r),
        .b      (x_r),
        .p      (sq)
    );

    // Stage 3: scale by c and sign-extend the guard bits straight into data_out.
    cheb_mult_stage #(.AW(2*WL), .BW(CL), .PW(OUT)) u_out (
        .clock  (clock),
        .resetn (resetn),
        .a      (sq),
        .b      (c_d),
        .p      (data_out)
    );

endmodule

// File: tb/tb_chebyshev_computation_v2.sv
// Scoreboard bench: a narrow (2,2,0) and a wide (8,8,4) instance share clock and reset.
module tb_chebyshev_computation_v2;
    import chebyshev_computation_v2_pkg::*;

    logic               clock = 1'b0;
    logic               resetn = 1'b1;
    logic signed [1:0]  din2 = '0;
    logic signed [1:0]  cin2 = '0;
    logic signed [5:0]  dout2;
    logic signed [7:0]  din8 = '0;
    logic signed [7:0]  cin8 = '0;
    logic signed [27:0] dout8;

    int     n_tests = 0;
    int     n_fail  = 0;
    longint q2[$];
    longint q8[$];

    always #5 clock = ~clock;

    chebyshev_computation_v2 #(.WL(2), .CL(2), .WIDENING(0)) dut (
        .clock(clock), .resetn(resetn), .data_in(din2), .coeff_in(cin2), .data_out(dout2)
    );

    chebyshev_computation_v2 #(.WL(8), .CL(8), .WIDENING(4)) dut8 (
        .clock(clock), .resetn(resetn), .data_in(din8), .coeff_in(cin8), .data_out(dout8)
    );

    // After reset the output stage and the square stage both hold zero.
    task automatic flush_model();
        q2.delete();
        q8.delete();
        for (int i = 0; i < PIPE_DEPTH - 1; i++) begin
            q2.push_back(0);
            q8.push_back(0);
        end
    endtask

    // Drive one pair into each DUT, clock it, and pop the expectation now due at the output.
    task automatic cycle(input int x2, input int c2, input int x8, input int c8,
                         output bit v, output longint e2, output longint e8);
        din2 = 2'(x2);
        cin2 = 2'(c2);
        din8 = 8'(x8);
        cin8 = 8'(c8);
        @(posedge clock);
        q2.push_back(longint'(c2) * x2 * x2);
        q8.push_back(longint'(c8) * x8 * x8);
        #1;
        v = (q2.size() >= PIPE_DEPTH);
        e2 = 0;
        e8 = 0;
        if (v) begin
            e2 = q2.pop_front();
            e8 = q8.pop_front();
        end
    endtask

    task automatic test_reset();
        bit v;
        longint e2, e8;
        cycle(1, 1, 100, 50, v, e2, e8);
        #3;
        din2 = 2'sd1; cin2 = 2'sd1; din8 = 8'sd127; cin8 = 8'sd127;
        resetn = 1'b1;
        flush_model();
        #1;
        n_tests++;
        if (dout2 !== 6'sd0 || dout8 !== 28'sd0) begin
            n_fail++;
            $display("FAIL reset_async: dout2=%0d dout8=%0d required 0", dout2, dout8);
        end
        @(posedge clock);
        #1;
        n_tests++;
        if (dout2 !== 6'sd0 || dout8 !== 28'sd0) begin
            n_fail++;
            $display("FAIL reset_hold: dout2=%0d dout8=%0d required 0", dout2, dout8);
        end
        #3;
        resetn = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle(1, 1, 3, 5, v, e2, e8);
            n_tests++;
            if (!v || longint'(dout2) !== e2 || longint'(dout8) !== e8) begin
                n_fail++;
                $display("FAIL reset_release[%0d]: dout2=%0d dout8=%0d required %0d %0d",
                         i, dout2, dout8, e2, e8);
            end
        end
    endtask

    task automatic test_stream();
        int xs[5] = '{1, 1, 1, 0, 0};
        int cs[5] = '{1, 1, 0, 0, 0};
        bit v;
        longint e2, e8;
        for (int i = 0; i < 5; i++) begin
            cycle(xs[i], cs[i], xs[i] * 7, cs[i] * 9, v, e2, e8);
            n_tests++;
            if (!v || longint'(dout2) !== e2 || longint'(dout8) !== e8) begin
                n_fail++;
                $display("FAIL stream[%0d]: dout2=%0d dout8=%0d required %0d %0d",
                         i, dout2, dout8, e2, e8);
            end
        end
    endtask

    task automatic test_corners();
        int xs[6] = '{-2, -2, 1, -1, 0, 0};
        int cs[6] = '{-2, 1, -2, -1, 0, 0};
        bit v;
        longint e2, e8;
        for (int i = 0; i < 6; i++) begin
            cycle(xs[i], cs[i], xs[i] * 64, cs[i] * 64, v, e2, e8);
            n_tests++;
            if (!v || longint'(dout2) !== e2 || longint'(dout8) !== e8) begin
                n_fail++;
                $display("FAIL corner[%0d]: dout2=%0d dout8=%0d required %0d %0d",
                         i, dout2, dout8, e2, e8);
            end
        end
    endtask

    task automatic test_wide();
        int xs[5] = '{-128, 127, -128, 0, 0};
        int cs[5] = '{-128, 127, 127, 0, 0};
        bit v;
        longint e2, e8;
        for (int i = 0; i < 5; i++) begin
            cycle(0, 0, xs[i], cs[i], v, e2, e8);
            n_tests++;
            if (!v || longint'(dout8) !== e8 || longint'(dout2) !== e2) begin
                n_fail++;
                $display("FAIL wide[%0d]: dout8=%0d (%h) required %0d", i, dout8, dout8, e8);
            end
        end
    endtask

    task automatic test_midreset();
        bit v;
        longint e2, e8;
        for (int i = 0; i < 3; i++) cycle(-2, -2, -100 + i, 77, v, e2, e8);
        #3;
        resetn = 1'b1;
        flush_model();
        #1;
        n_tests++;
        if (dout2 !== 6'sd0 || dout8 !== 28'sd0) begin
            n_fail++;
            $display("FAIL midreset_async: dout2=%0d dout8=%0d required 0", dout2, dout8);
        end
        #9;
        resetn = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle(i < 2 ? 0 : -1, i < 2 ? 0 : -2, i < 2 ? 0 : 90, i < 2 ? 0 : -33, v, e2, e8);
            n_tests++;
            if (!v || longint'(dout2) !== e2 || longint'(dout8) !== e8) begin
                n_fail++;
                $display("FAIL midreset_after[%0d]: dout2=%0d dout8=%0d required %0d %0d",
                         i, dout2, dout8, e2, e8);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit v;
        longint e2, e8;
        int errs = 0;
        for (int i = 0; i < 10000; i++) begin
            cycle(int'($urandom_range(0, 3)) - 2, int'($urandom_range(0, 3)) - 2,
                  int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                  v, e2, e8);
            n_tests++;
            if (!v || longint'(dout2) !== e2 || longint'(dout8) !== e8) begin
                n_fail++;
                errs++;
                if (errs <= 10)
                    $display("FAIL random[%0d]: dout2=%0d dout8=%0d required %0d %0d",
                             i, dout2, dout8, e2, e8);
            end
        end
    endtask

    initial begin
        flush_model();
        repeat (2) @(posedge clock);
        #1;
        n_tests++;
        if (dout2 !== 6'sd0 || dout8 !== 28'sd0) begin
            n_fail++;
            $display("FAIL power_on_reset: dout2=%0d dout8=%0d required 0", dout2, dout8);
        end
        #3;
        resetn = 1'b0;
        test_reset();
        test_stream();
        test_corners();
        test_wide();
        test_midreset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
